// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract unit for the embedding datapath.
// Processes an N-bit operand pair D bits per clock, LSB digit first,
// with optional unsigned saturation and signed-overflow detection.
module digit_serial_addsub #(
    parameter int N   = 32,
    parameter int D   = 4,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int NDIG = N / D;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    // A digit width that does not tile the operand is a configuration error.
    if (N % D != 0) begin : g_bad_digit_width
        $error("digit_serial_addsub: D must divide N");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    logic [N-1:0]  res;
    logic [N-1:0]  res_nx;
    logic [N-1:0]  sat_res;
    logic          op_sub;
    logic          carry;
    logic [CW-1:0] cnt;
    logic [D-1:0]  a_dig;
    logic [D-1:0]  b_dig;
    logic [D-1:0]  prop;
    logic [D-1:0]  s_dig;
    logic [D:0]    c_chain;
    logic          last_dig;
    logic          accept;

    assign last_dig = (cnt == LAST);
    assign accept   = in_valid && (state == IDLE);

    // One digit slice: a ripple of mux-based full adders fed by the registered carry.
    always_comb begin
        a_dig      = op_a[cnt*D +: D];
        b_dig      = op_b[cnt*D +: D];
        prop       = '0;
        s_dig      = '0;
        c_chain    = '0;
        c_chain[0] = carry;
        for (int i = 0; i < D; i++) begin
            prop[i]      = a_dig[i] ^ b_dig[i];
            s_dig[i]     = prop[i] ^ c_chain[i];
            c_chain[i+1] = prop[i] ? c_chain[i] : a_dig[i];
        end
    end

    // Merge the current digit into the partial result and apply the optional clamp.
    always_comb begin
        res_nx              = res;
        res_nx[cnt*D +: D]  = s_dig;
        sat_res             = res_nx;
        if (SAT) begin
            if (!op_sub && c_chain[D]) begin
                sat_res = '1;
            end else if (op_sub && !c_chain[D]) begin
                sat_res = '0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last_dig) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand capture, per-digit carry/result update and final result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            op_sub <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            res    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            op_a   <= a;
            op_b   <= sub ? ~b : b;
            op_sub <= sub;
            carry  <= sub;
            cnt    <= '0;
        end else if (state == RUN) begin
            res   <= res_nx;
            carry <= c_chain[D];
            cnt   <= cnt + 1'b1;
            if (last_dig) begin
                sum  <= sat_res;
                cout <= c_chain[D];
                ovf  <= c_chain[D] ^ c_chain[D-1];
            end
        end
    end

endmodule
